// File: rtl/serial_parity_tx.sv
// LSB-first serial transmitter with frame strobes for the serial parity checker.
// Define SERIAL_PARITY_TX_PARITY_EN to append a generated parity bit to each frame.
module serial_parity_tx #(
  parameter int WIDTH      = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef SERIAL_PARITY_TX_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
  logic r_par;
`else
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
  logic w_unused_odd;
  assign w_unused_odd = (ODD_PARITY != 0);
`endif

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_x, r_xv, r_sof, r_eof, r_busy;

  // rst is folded in so ready only rises once reset has been released.
  assign din_ready = (r_state == S_IDLE) && !rst;
  assign x         = r_x;
  assign x_valid   = r_xv;
  assign sof       = r_sof;
  assign eof       = r_eof;
  assign busy      = r_busy;

  // r_x holds the bit on the line this cycle, r_cnt its index; bit 0 is
  // loaded on the accept edge so it is on the line one cycle after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_xv    <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SERIAL_PARITY_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (din_valid) begin
            r_state <= S_SHIFT;
            r_sh    <= din >> 1;
            r_cnt   <= '0;
            r_x     <= din[0];
            r_xv    <= 1'b1;
            r_sof   <= 1'b1;
            r_eof   <= 1'b0;
            r_busy  <= 1'b1;
`ifdef SERIAL_PARITY_TX_PARITY_EN
            // Seeded with the parity sense, bit 0 already folded in.
            r_par   <= (ODD_PARITY != 0) ^ din[0];
`endif
          end
        end
        S_SHIFT: begin
          r_sof <= 1'b0;
          if (r_cnt == LAST) begin
`ifdef SERIAL_PARITY_TX_PARITY_EN
            r_state <= S_PARITY;
            r_x     <= r_par;
            r_eof   <= 1'b1;
`else
            r_state <= S_IDLE;
            r_x     <= 1'b0;
            r_xv    <= 1'b0;
            r_eof   <= 1'b0;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_x   <= r_sh[0];
            r_sh  <= r_sh >> 1;
`ifdef SERIAL_PARITY_TX_PARITY_EN
            r_par <= r_par ^ r_sh[0];
`else
            r_eof <= (r_cnt == PENULT);
`endif
          end
        end
`ifdef SERIAL_PARITY_TX_PARITY_EN
        S_PARITY: begin
          r_state <= S_IDLE;
          r_x     <= 1'b0;
          r_xv    <= 1'b0;
          r_eof   <= 1'b0;
          r_busy  <= 1'b0;
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_xv    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_tx.sv
// Randomized bench for serial_parity_tx: even and odd parity instances share
// stimulus; outputs are compared against a frame model built from the word.
module tb_serial_parity_tx;
  localparam int W = 8;
`ifdef SERIAL_PARITY_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  localparam logic [5:0] IDLE_V = 6'b100000;

  logic clk = 1'b0, clk_en = 1'b0;
  logic rst, din_valid;
  logic [W-1:0] din;
  logic r0, x0, v0, s0, e0, b0;
  logic r1, x1, v1, s1, e1, b1;
  int checks = 0, errors = 0, cyc = 0;

  serial_parity_tx #(.WIDTH(W), .ODD_PARITY(0)) u_even (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(r0),
    .x(x0), .x_valid(v0), .sof(s0), .eof(e0), .busy(b0));
  serial_parity_tx #(.WIDTH(W), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(r1),
    .x(x1), .x_valid(v1), .sof(s1), .eof(e1), .busy(b1));

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end
  always @(posedge clk) cyc++;

  wire [5:0] o0 = {r0, x0, v0, s0, e0, b0};
  wire [5:0] o1 = {r1, x1, v1, s1, e1, b1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame position k: data bits LSB first, then (optionally) the parity bit.
  function automatic logic [5:0] exp_vec(input logic [W-1:0] w, input int k, input bit odd);
    logic b;
    if (k >= FL) return IDLE_V;
    if (k < W) b = w[k];
    else b = odd ^ ($countones(w) % 2 == 1);
    return {1'b0, b, 1'b1, k == 0, k == FL - 1, 1'b1};
  endfunction

  // Starts at the negedge carrying bit 0; ends at the following idle negedge.
  task automatic check_frame(input string tag, input logic [W-1:0] w);
    for (int k = 0; k <= FL; k++) begin
      chk($sformatf("%s_e_k%0d", tag, k), o0, exp_vec(w, k, 1'b0));
      chk($sformatf("%s_o_k%0d", tag, k), o1, exp_vec(w, k, 1'b1));
      if (k < FL) @(negedge clk);
    end
  endtask

  // Called at an idle negedge; returns at the negedge carrying bit 0.
  task automatic send(input logic [W-1:0] w);
    din = w;
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    din = W'($urandom);
  endtask

  initial begin
    int a0, a1;
    logic [W-1:0] w;
    rst = 1'b0; din = '0; din_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_async_e", o0, 6'b0);
    chk("rst_async_o", o1, 6'b0);
    clk_en = 1'b1;
    din_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_held", o0, 6'b0);
    din_valid = 1'b0;
    rst = 1'b0;
    #1 chk("rst_rel_e", o0, IDLE_V);
    chk("rst_rel_o", o1, IDLE_V);
    @(negedge clk);

    send(8'hA5); check_frame("a5", 8'hA5);
    send(8'h07); check_frame("h07", 8'h07);

    // Back-to-back with valid held: one idle cycle, accept spacing FL+1.
    din = 8'hFF; din_valid = 1'b1;
    @(posedge clk); a0 = cyc;
    @(negedge clk); din = 8'h00;
    check_frame("ff", 8'hFF);
    @(posedge clk); a1 = cyc;
    @(negedge clk); din_valid = 1'b0;
    chk("b2b_spacing", a1 - a0, FL + 1);
    check_frame("h00", 8'h00);

    // Reset during bit 3: frame discarded, never an eof afterwards.
    send(8'h3C);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("3c_k%0d", k), o0, exp_vec(8'h3C, k, 1'b0));
      if (k < 3) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1 chk("midrst_e", o0, 6'b0);
    chk("midrst_o", o1, 6'b0);
    @(negedge clk);
    chk("midrst_hold", o0, 6'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("post_rst_%0d", k), o0, IDLE_V);
      @(negedge clk);
    end
    send(8'h81); check_frame("h81", 8'h81);

    for (int i = 0; i < 24; i++) begin
      w = W'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(w);
      check_frame($sformatf("rnd%0d", i), w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
